// File: rtl/alu_issue_unit.sv
// Command-issue stage feeding a 4-bit combinational ALU: buffers commands in a FIFO,
// drives one at a time into the ALU and holds the registered result for downstream.
// Optional result-handshake counter on res_count when ALU_ISSUE_CNT_EN is defined.
module alu_issue_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_y,
    output logic [2:0] res_sel,
`ifdef ALU_ISSUE_CNT_EN
    output logic [7:0] res_count,
`endif
    output logic [1:0] dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [10:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [10:0]     head;

    // Both ports use valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high; valid and its payload stay stable until then.
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = !empty && ((state == IDLE) || (state == HOLD && res_ready));
    assign head      = mem[rd_ptr];
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ALU operand registers change only on a pop; result registers only in DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_sel   <= '0;
        end else begin
            if (pop) begin
                alu_a   <= head[10:7];
                alu_b   <= head[6:3];
                alu_sel <= head[2:0];
            end
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    res_y     <= alu_y;
                    res_sel   <= alu_sel;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= empty ? IDLE : DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count <= '0;
        end else if (res_valid && res_ready && res_count != 8'hff) begin
            res_count <= res_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small add/subtract ALU in the loop;
// results are checked in order against an expected queue of hand-computed values.
module tb_alu_issue_unit;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_y;
    logic [2:0] res_sel;
    logic [1:0] dbg_state;
`ifdef ALU_ISSUE_CNT_EN
    logic [7:0] res_count;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_hs = -1;
    bit         rate_chk = 0;
    logic [6:0] exp_q[$];

    alu_issue_unit #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_sel   (res_sel),
`ifdef ALU_ISSUE_CNT_EN
        .res_count (res_count),
`endif
        .dbg_state (dbg_state)
    );

    // Team ALU: 000 add, 001 subtract, a few logic ops otherwise.
    always_comb begin
        case (alu_sel)
            3'b000:  alu_y = alu_a + alu_b;
            3'b001:  alu_y = alu_a - alu_b;
            3'b010:  alu_y = alu_a & alu_b;
            3'b011:  alu_y = alu_a | alu_b;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                        input logic [3:0] y, input bit track);
        int k;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = s;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("push_accept_timeout", (k < 200), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (track) exp_q.push_back({s, y});
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || res_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", (k < budget), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a handshake completes on the edge after this sample.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            check("result_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("result_sel_y", {res_sel, res_y}, exp_q.pop_front());
            end
            if (rate_chk) begin
                if (last_hs >= 0) check("result_interval", cyc - last_hs, 2);
                last_hs = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res", {res_sel, res_y}, 0);
`ifdef ALU_ISSUE_CNT_EN
        check("rst_res_count", res_count, 0);
`endif
        step();
        rst_n = 1'b1;

        // Single add with latency checks
        res_ready = 1'b1;
        push(4'd3, 4'd2, 3'b000, 4'd5, 1);
        @(negedge clk);
        check("lat_n_res_valid", res_valid, 0);
        step();
        @(negedge clk);
        check("lat_n1_alu", {alu_a, alu_b, alu_sel}, {4'd3, 4'd2, 3'b000});
        check("lat_n1_res_valid", res_valid, 0);
        step();
        @(negedge clk);
        check("lat_n2_res_valid", res_valid, 1);
        check("lat_n2_res", {res_sel, res_y}, {3'b000, 4'd5});
        step();
        wait_drain(50);

        // Back-to-back in order, one result every 2 cycles
        last_hs  = -1;
        rate_chk = 1;
        push(4'd3, 4'd2, 3'b000, 4'd5, 1);
        push(4'd3, 4'd2, 3'b001, 4'd1, 1);
        push(4'd9, 4'd8, 3'b000, 4'd1, 1);
        push(4'd1, 4'd2, 3'b001, 4'd15, 1);
        wait_drain(50);
        rate_chk = 0;

        // Full / backpressure
        res_ready = 1'b0;
        push(4'd1, 4'd1, 3'b000, 4'd2, 1);
        push(4'd7, 4'd2, 3'b001, 4'd5, 1);
        push(4'd8, 4'd8, 3'b000, 4'd0, 1);
        push(4'd0, 4'd1, 3'b001, 4'd15, 1);
        push(4'd6, 4'd5, 3'b000, 4'd11, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_cmd_ready", cmd_ready, 0);
            check("full_hold_valid", res_valid, 1);
            check("full_hold_res", {res_sel, res_y}, {3'b000, 4'd2});
            step();
        end
        cmd_valid = 1'b1;
        cmd_a     = 4'd2;
        cmd_b     = 4'd9;
        cmd_sel   = 3'b001;
        res_ready = 1'b1;
        @(negedge clk);
        check("unfill_before_pop", cmd_ready, 0);
        step();
        @(negedge clk);
        check("unfill_after_pop", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        exp_q.push_back({3'b001, 4'd9});
        wait_drain(100);

        // Continuous cmd_valid while results drain
        for (int i = 0; i < 10; i++) begin
            push(4'(i), 4'd1, 3'(i % 2), (i % 2 == 0) ? 4'(i + 1) : 4'(i - 1), 1);
        end
        wait_drain(100);

        // Reset mid-operation with one in HOLD and two queued
        res_ready = 1'b0;
        push(4'd5, 4'd5, 3'b000, 4'd10, 0);
        push(4'd6, 4'd6, 3'b000, 4'd12, 0);
        push(4'd7, 4'd7, 3'b000, 4'd14, 0);
        step();
        @(negedge clk);
        check("pre_rst_hold", {res_valid, res_sel, res_y}, {1'b1, 3'b000, 4'd10});
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_alu", {alu_a, alu_b, alu_sel}, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res", {res_sel, res_y}, 0);
`ifdef ALU_ISSUE_CNT_EN
        check("mid_rst_res_count", res_count, 0);
`endif
        step();
        step();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        push(4'd4, 4'd4, 3'b000, 4'd8, 1);
        wait_drain(50);
        repeat (10) step();
        @(negedge clk);
        check("post_rst_idle", res_valid, 0);
        check("post_rst_queue", exp_q.size(), 0);
        step();

`ifdef ALU_ISSUE_CNT_EN
        check("count_one", res_count, 1);
        for (int i = 0; i < 299; i++) begin
            push(4'(i), 4'd0, 3'b000, 4'(i), 1);
        end
        wait_drain(100);
        check("count_saturated", res_count, 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
